// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with lock/timeout between the CPU LSU (port 0) and an auxiliary master (port 1).
// Grant/strobes combinational, read data 1 cycle after grant; a losing port 0 raises m0_stall until granted.
module data_mem_arbiter #(
    parameter int LOCK_MAX = 16,
    parameter int LOCK_CW  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic        m0_memwrite,
    input  logic        m0_memread,
    input  logic [3:0]  m0_sign_mask,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic        m1_memwrite,
    input  logic        m1_memread,
    input  logic [3:0]  m1_sign_mask,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic        m0_stall,
    output logic        lock_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [LOCK_CW-1:0]   cnt_q, cnt_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 rd_port_q, rd_port_d;
    logic                 lock_err_q, lock_err_d;

    logic m0_req, m1_req;
    logic gnt0, gnt1;
    logic any_gnt;
    logic sel_rd, sel_wr;
    logic timeout;

    assign m0_req  = m0_memread | m0_memwrite;
    assign m1_req  = m1_memread | m1_memwrite;
    assign timeout = (cnt_q == LOCK_CW'(LOCK_MAX));

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    // On a tie the port that did not win last time is served.
                    if (m0_req && m1_req) begin
                        gnt0 = last_q;
                        gnt1 = ~last_q;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                    if (gnt0 && m0_lock) begin
                        state_d = LOCK0;
                        cnt_d   = LOCK_CW'(1);
                    end else if (gnt1 && m1_lock) begin
                        state_d = LOCK1;
                        cnt_d   = LOCK_CW'(1);
                    end
                end
                LOCK0: begin
                    gnt0 = m0_req;
                    if (timeout) begin
                        state_d    = ARB;
                        cnt_d      = '0;
                        lock_err_d = 1'b1;
                        last_d     = 1'b0;
                    end else if (!m0_lock) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LOCK_CW'(1);
                    end
                end
                LOCK1: begin
                    gnt1 = m1_req;
                    if (timeout) begin
                        state_d    = ARB;
                        cnt_d      = '0;
                        lock_err_d = 1'b1;
                        last_d     = 1'b1;
                    end else if (!m1_lock) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LOCK_CW'(1);
                    end
                end
                default: begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            endcase
            if (gnt0) begin
                last_d = 1'b0;
            end else if (gnt1) begin
                last_d = 1'b1;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_rd    = gnt1 ? m1_memread  : m0_memread;
    assign sel_wr    = gnt1 ? m1_memwrite : m0_memwrite;
    assign rd_vld_d  = any_gnt & sel_rd;
    assign rd_port_d = gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_port_q  <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_port_q  <= rd_port_d;
            lock_err_q <= lock_err_d;
        end
    end

    // With no grant the address/data lanes park on port 0 and both strobes stay low.
    always_comb begin
        mem_addr       = gnt1 ? m1_addr       : m0_addr;
        mem_write_data = gnt1 ? m1_write_data : m0_write_data;
        mem_sign_mask  = gnt1 ? m1_sign_mask  : m0_sign_mask;
        mem_memread    = any_gnt & sel_rd;
        mem_memwrite   = any_gnt & sel_wr & ~sel_rd;
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_stall  = m0_req & ~gnt0 & ~reset;
    assign m0_rvalid = rd_vld_q & ~rd_port_q & ~reset;
    assign m1_rvalid = rd_vld_q & rd_port_q & ~reset;
    assign rdata     = mem_read_data;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 1-cycle-latency word memory model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
    logic        m0_memwrite, m0_memread, m0_lock, m1_memwrite, m1_memread, m1_lock;
    logic [3:0]  m0_sign_mask, m1_sign_mask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m0_stall, lock_err;
    logic [31:0] rdata, mem_addr, mem_write_data;
    logic        mem_memwrite, mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_arbiter #(.LOCK_MAX(4), .LOCK_CW(3)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_write_data(m0_write_data), .m0_memwrite(m0_memwrite),
        .m0_memread(m0_memread), .m0_sign_mask(m0_sign_mask), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_addr(m1_addr), .m1_write_data(m1_write_data), .m1_memwrite(m1_memwrite),
        .m1_memread(m1_memread), .m1_sign_mask(m1_sign_mask), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .m0_stall(m0_stall), .lock_err(lock_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Word memory preloaded with A000_00xx (xx = word index) on the first edge.
    logic [31:0] mem [0:255];
    bit          mem_rdy;
    always @(posedge clk) begin
        if (!mem_rdy) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem_rdy <= 1'b1;
        end else begin
            if (mem_memwrite) mem[mem_addr[9:2]] <= mem_write_data;
            if (mem_memread)  mem_read_data <= mem[mem_addr[9:2]];
        end
    end

    // {m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, lock_err}
    logic [5:0] obs;
    assign obs = {m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, lock_err};

    // c = {memread, memwrite, lock}
    task automatic drive(input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] d1);
        {m0_memread, m0_memwrite, m0_lock} = c0;
        m0_addr = a0;
        m0_write_data = d0;
        {m1_memread, m1_memwrite, m1_lock} = c1;
        m1_addr = a1;
        m1_write_data = d1;
    endtask

    task automatic test_reset;
        drive(3'b100, 32'h10, 0, 3'b100, 32'h20, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_err++; $display("FAIL reset_obs_in_reset: got %b want 000000", obs);
        end
        n_cmp++;
        if ({mem_memread, mem_memwrite} !== 2'b00) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00", {mem_memread, mem_memwrite});
        end
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 0, 0, 3'b000, 0, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_err++; $display("FAIL reset_obs_idle: got %b want 000000", obs);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [5:0]  e_obs [0:4];
        logic [31:0] e_rd  [0:4];
        logic [31:0] e_adr;
        e_obs = '{6'b100000, 6'b011100, 6'b100010, 6'b011100, 6'b000010};
        e_rd  = '{32'h0, 32'hA000_0004, 32'hA000_0008, 32'hA000_0004, 32'hA000_0008};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(3'b100, 32'h10, 0, 3'b100, 32'h20, 0);
            else       drive(3'b000, 32'h10, 0, 3'b000, 32'h20, 0);
            #1;
            n_cmp++;
            if (obs !== e_obs[i]) begin
                n_err++; $display("FAIL rr_obs[%0d]: got %b want %b", i, obs, e_obs[i]);
            end
            if (i < 4) begin
                e_adr = (i % 2 == 0) ? 32'h10 : 32'h20;
                n_cmp++;
                if (mem_addr !== e_adr || mem_memread !== 1'b1) begin
                    n_err++; $display("FAIL rr_mem[%0d]: got %h/%b want %h/1", i, mem_addr, mem_memread, e_adr);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (rdata !== e_rd[i]) begin
                    n_err++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata, e_rd[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_read_after_write;
        m1_sign_mask = 4'h3;
        drive(3'b000, 32'h0, 0, 3'b010, 32'h40, 32'hDEAD_BEEF);
        #1;
        n_cmp++;
        if (obs !== 6'b010000 || {mem_memread, mem_memwrite} !== 2'b01) begin
            n_err++; $display("FAIL raw_write: got %b/%b want 010000/01", obs, {mem_memread, mem_memwrite});
        end
        n_cmp++;
        if (mem_addr !== 32'h40 || mem_write_data !== 32'hDEAD_BEEF || mem_sign_mask !== 4'h3) begin
            n_err++; $display("FAIL raw_wlanes: got %h %h %h want 40 deadbeef 3", mem_addr, mem_write_data, mem_sign_mask);
        end
        @(negedge clk);
        drive(3'b100, 32'h40, 0, 3'b000, 32'h0, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b100000 || {mem_memread, mem_memwrite} !== 2'b10 || mem_sign_mask !== 4'hF) begin
            n_err++; $display("FAIL raw_read: got %b/%b/%h want 100000/10/f", obs, {mem_memread, mem_memwrite}, mem_sign_mask);
        end
        @(negedge clk);
        drive(3'b000, 32'h40, 0, 3'b000, 32'h0, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000100 || rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL raw_rvalid: got %b/%h want 000100/deadbeef", obs, rdata);
        end
        @(negedge clk);
        m1_sign_mask = 4'hF;
    endtask

    task automatic test_lock;
        logic [5:0]  e_obs [0:4];
        logic [31:0] e_rd  [0:4];
        e_obs = '{6'b011000, 6'b011010, 6'b100000, 6'b010100, 6'b000010};
        e_rd  = '{32'h0, 32'hA000_0020, 32'h0, 32'hA000_0004, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(3'b100, 32'h10, 0, 3'b101, 32'h80, 0);
                1: drive(3'b100, 32'h10, 0, 3'b010, 32'h80, 32'h1234_5678);
                2: drive(3'b100, 32'h10, 0, 3'b000, 32'h80, 0);
                3: drive(3'b000, 32'h10, 0, 3'b100, 32'h80, 0);
                default: drive(3'b000, 32'h10, 0, 3'b000, 32'h80, 0);
            endcase
            #1;
            n_cmp++;
            if (obs !== e_obs[i]) begin
                n_err++; $display("FAIL lock_obs[%0d]: got %b want %b", i, obs, e_obs[i]);
            end
            if (e_obs[i][2:1] != 2'b00) begin
                n_cmp++;
                if (rdata !== e_rd[i]) begin
                    n_err++; $display("FAIL lock_rdata[%0d]: got %h want %h", i, rdata, e_rd[i]);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({mem_memread, mem_memwrite} !== 2'b01 || mem_addr !== 32'h80) begin
                    n_err++; $display("FAIL lock_unlock_write: got %b/%h want 01/80", {mem_memread, mem_memwrite}, mem_addr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_timeout;
        logic [5:0]  e_obs [0:8];
        logic [31:0] e_rd  [0:8];
        e_obs = '{6'b010000, 6'b011010, 6'b011010, 6'b011010, 6'b011010,
                  6'b100011, 6'b010100, 6'b010010, 6'b000010};
        e_rd  = '{32'h0, 32'hA000_0008, 32'hA000_0008, 32'hA000_0008, 32'hA000_0008,
                  32'hA000_0008, 32'hA000_0004, 32'hA000_0008, 32'hA000_0008};
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       drive(3'b000, 32'h10, 0, 3'b101, 32'h20, 0);
                1, 2, 3, 4, 5:
                         drive(3'b100, 32'h10, 0, 3'b101, 32'h20, 0);
                6:       drive(3'b000, 32'h10, 0, 3'b101, 32'h20, 0);
                7:       drive(3'b000, 32'h10, 0, 3'b100, 32'h20, 0);
                default: drive(3'b000, 32'h10, 0, 3'b000, 32'h20, 0);
            endcase
            #1;
            n_cmp++;
            if (obs !== e_obs[i]) begin
                n_err++; $display("FAIL timeout_obs[%0d]: got %b want %b", i, obs, e_obs[i]);
            end
            if (e_obs[i][2:1] != 2'b00) begin
                n_cmp++;
                if (rdata !== e_rd[i]) begin
                    n_err++; $display("FAIL timeout_rdata[%0d]: got %h want %h", i, rdata, e_rd[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_read;
        drive(3'b101, 32'h10, 0, 3'b000, 32'h20, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b100000 || mem_memread !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_grant: got %b/%b want 100000/1", obs, mem_memread);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(3'b100, 32'h10, 0, 3'b100, 32'h20, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000000 || {mem_memread, mem_memwrite} !== 2'b00) begin
            n_err++; $display("FAIL rst_mid_in_reset: got %b/%b want 000000/00", obs, {mem_memread, mem_memwrite});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++; $display("FAIL rst_mid_first_tie: got %b want 100000", obs);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== 6'b011100 || rdata !== 32'hA000_0004) begin
            n_err++; $display("FAIL rst_mid_second_tie: got %b/%h want 011100/a0000004", obs, rdata);
        end
        @(negedge clk);
        drive(3'b000, 32'h10, 0, 3'b000, 32'h20, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000010 || rdata !== 32'hA000_0008) begin
            n_err++; $display("FAIL rst_mid_drain: got %b/%h want 000010/a0000008", obs, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_both;
        drive(3'b110, 32'h40, 32'h0BAD_F00D, 3'b000, 32'h0, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b100000 || {mem_memread, mem_memwrite} !== 2'b10) begin
            n_err++; $display("FAIL rw_both_strobes: got %b/%b want 100000/10", obs, {mem_memread, mem_memwrite});
        end
        @(negedge clk);
        drive(3'b000, 32'h40, 0, 3'b000, 32'h0, 0);
        #1;
        n_cmp++;
        if (obs !== 6'b000100 || rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rw_both_rdata: got %b/%h want 000100/deadbeef", obs, rdata);
        end
        @(negedge clk);
        drive(3'b100, 32'h40, 0, 3'b000, 32'h0, 0);
        @(negedge clk);
        drive(3'b000, 32'h40, 0, 3'b000, 32'h0, 0);
        #1;
        n_cmp++;
        if (m0_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rw_both_unchanged: got %b/%h want 1/deadbeef", m0_rvalid, rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        m0_sign_mask = 4'hF;
        m1_sign_mask = 4'hF;
        drive(3'b000, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_read_after_write();
        test_lock();
        test_lock_timeout();
        test_reset_mid_read();
        test_read_write_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
